// File: rtl/occupancy_counter.sv
// occupancy_counter: room occupancy count with BCD 7-segment display, full block and over-capacity alarm
module occupancy_counter #(
    parameter int CAPACITY     = 20,
    parameter int ALARM_CYCLES = 50000000,
    parameter int TIMER_W      = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_evt,
    input  logic             out_evt,
    output logic [6:0]       count,
    output logic [0:6]       hex0,
    output logic [0:6]       hex1,
    output logic             full,
    output logic             empty,
    output logic             block_in,
    output logic             alarm
);
    typedef enum logic [1:0] {S_EMPTY, S_OPEN, S_FULL, S_ALARM} state_t;
    localparam logic [6:0] CAP = 7'(CAPACITY);
    state_t state;
    logic [3:0] tens, ones;
    logic [TIMER_W-1:0] timer;
    logic in_s1, in_s2, in_h, in_arm, out_s1, out_s2, out_h, out_arm;
    logic [1:0] rdy;
    logic ent, ext, inc, dec;

    function automatic logic [0:6] seg(input logic [3:0] d);
        case (d)
            4'd0: seg = 7'b0000001;
            4'd1: seg = 7'b1001111;
            4'd2: seg = 7'b0010010;
            4'd3: seg = 7'b0000110;
            4'd4: seg = 7'b1001100;
            4'd5: seg = 7'b0100100;
            4'd6: seg = 7'b0100000;
            4'd7: seg = 7'b0001111;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
    endfunction

    // synchronize inputs; an input only arms once it is seen low after the pipe has filled,
    // so a level held high through reset release never counts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {in_s1, in_s2, in_h, in_arm} <= '0;
            {out_s1, out_s2, out_h, out_arm} <= '0;
            rdy <= '0;
        end else begin
            in_s1   <= in_evt;
            in_s2   <= in_s1;
            in_h    <= in_s2;
            out_s1  <= out_evt;
            out_s2  <= out_s1;
            out_h   <= out_s2;
            rdy     <= {rdy[0], 1'b1};
            in_arm  <= in_arm | (rdy[1] & ~in_s2);
            out_arm <= out_arm | (rdy[1] & ~out_s2);
        end
    end

    assign ent = in_s2 & ~in_h & in_arm;
    assign ext = out_s2 & ~out_h & out_arm;
    assign inc = ent & ~ext;
    assign dec = ext & ~ent;

    // occupancy state machine with binary and BCD counts kept in step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
            count <= '0;
            tens  <= '0;
            ones  <= '0;
            timer <= '0;
        end else if (inc) begin
            if (state == S_FULL || state == S_ALARM) begin
                state <= S_ALARM;
                timer <= TIMER_W'(ALARM_CYCLES - 1);
            end else begin
                count <= count + 7'd1;
                ones  <= ones == 4'd9 ? 4'd0 : ones + 4'd1;
                tens  <= ones == 4'd9 ? tens + 4'd1 : tens;
                state <= count + 7'd1 == CAP ? S_FULL : S_OPEN;
            end
        end else if (dec && state != S_EMPTY) begin
            count <= count - 7'd1;
            ones  <= ones == 4'd0 ? 4'd9 : ones - 4'd1;
            tens  <= ones == 4'd0 ? tens - 4'd1 : tens;
            timer <= '0;
            state <= count == 7'd1 ? S_EMPTY : S_OPEN;
        end else if (state == S_ALARM) begin
            timer <= timer == '0 ? '0 : timer - TIMER_W'(1);
            state <= timer == '0 ? S_FULL : S_ALARM;
        end
    end

    assign full     = count == CAP;
    assign empty    = count == 7'd0;
    assign block_in = state == S_FULL || state == S_ALARM;
    assign alarm    = state == S_ALARM;
    assign hex0     = seg(ones);
    assign hex1     = tens == 4'd0 ? 7'b1111111 : seg(tens);
endmodule

// File: tb/tb_occupancy_counter.sv
// tb_occupancy_counter: table-driven and sequence checks of occupancy_counter with CAPACITY=12, ALARM_CYCLES=4
module tb_occupancy_counter;
    typedef struct packed {
        logic [6:0] c;
        logic [0:6] h0;
        logic [0:6] h1;
        logic f, e, b, a;
    } exp_t;
    typedef struct {
        logic i, o;
        int c;
        logic a, b;
    } vec_t;

    logic clk = 0, rst = 1, in_evt = 0, out_evt = 0;
    logic [6:0] count;
    logic [0:6] hex0, hex1;
    logic full, empty, block_in, alarm;
    int checks = 0, failures = 0, last_cnt = 0;
    exp_t q[$];
    vec_t vecs[$];

    occupancy_counter #(.CAPACITY(12), .ALARM_CYCLES(4), .TIMER_W(26)) dut (
        .clk(clk), .rst(rst), .in_evt(in_evt), .out_evt(out_evt), .count(count),
        .hex0(hex0), .hex1(hex1), .full(full), .empty(empty), .block_in(block_in), .alarm(alarm)
    );

    always #5 clk = ~clk;

    function automatic logic [0:6] seg_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    function automatic exp_t mk(input int c, input logic a, input logic b);
        exp_t e;
        e.c  = 7'(c);
        e.h0 = seg_of(c % 10);
        e.h1 = (c / 10 == 0) ? 7'b1111111 : seg_of(c / 10);
        e.f  = c == 12;
        e.e  = c == 0;
        e.b  = b;
        e.a  = a;
        return e;
    endfunction

    function automatic exp_t cur();
        return {count, hex0, hex1, full, empty, block_in, alarm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
        in_evt = 0;
        out_evt = 0;
        repeat (6) @(posedge clk);
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        in_evt = v.i;
        out_evt = v.o;
        q.push_back(mk(v.c, v.a, v.b));
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("latency%0d", idx), 32'(count), 32'(last_cnt));
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d", idx), 32'(cur()), 32'(q.pop_front()));
        last_cnt = v.c;
        repeat (1) @(posedge clk);
        settle();
    endtask

    task automatic wait_alarm(input string nm);
        int n = 0;
        while (!alarm && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, 32'(alarm), 32'd1);
    endtask

    initial begin
        int n;
        vecs.push_back('{1'b0, 1'b1, 0, 1'b0, 1'b0});
        for (int k = 1; k <= 9; k++) vecs.push_back('{1'b1, 1'b0, k, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 9, 1'b0, 1'b0});
        for (int k = 10; k <= 12; k++) vecs.push_back('{1'b1, 1'b0, k, 1'b0, k == 12});
        vecs.push_back('{1'b1, 1'b1, 12, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 12, 1'b1, 1'b1});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_held", 32'(cur()), 32'(mk(0, 0, 0)));
        rst = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_released", 32'(cur()), 32'(mk(0, 0, 0)));

        foreach (vecs[k]) apply(vecs[k], k);

        @(posedge clk);
        #1;
        in_evt = 1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (alarm) n++;
        end
        chk("alarm_len", 32'(n), 32'd4);
        chk("after_alarm", 32'(cur()), 32'(mk(12, 0, 1)));
        settle();

        @(posedge clk);
        #1;
        in_evt = 1;
        wait_alarm("alarm_for_exit");
        out_evt = 1;
        q.push_back(mk(11, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk("alarm_before_exit", 32'({count, alarm}), 32'({7'd12, 1'b1}));
        @(posedge clk);
        #1;
        chk("exit_in_alarm", 32'(cur()), 32'(q.pop_front()));
        settle();

        @(posedge clk);
        #1;
        in_evt = 1;
        q.push_back(mk(12, 0, 1));
        repeat (100) @(posedge clk);
        #1;
        chk("held_level_once", 32'(cur()), 32'(q.pop_front()));
        settle();

        @(posedge clk);
        #1;
        in_evt = 1;
        wait_alarm("alarm_for_reset");
        @(negedge clk);
        #1;
        rst = 1;
        #1;
        chk("async_reset", 32'(cur()), 32'(mk(0, 0, 0)));
        @(negedge clk);
        rst = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("held_through_reset", 32'(cur()), 32'(mk(0, 0, 0)));
        in_evt = 0;
        repeat (4) @(posedge clk);
        #1;
        in_evt = 1;
        q.push_back(mk(1, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        chk("repulse_after_reset", 32'(cur()), 32'(q.pop_front()));
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
